// File: rtl/step_ctrl_pkg.sv
// Shared encodings for the step/run clock-enable controller.
// Holds the mode encodings and the controller FSM state type.
package step_ctrl_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;
  localparam logic [1:0] MODE_HALT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, polarity normalisation, stable-count
// debounce and a one-cycle press pulse on the debounced rising edge.
module key_debounce #(
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_pin_i,
  output logic level_o,
  output logic press_o
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            pin_norm;
  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  assign pin_norm = KEY_ACTIVE_LOW ? ~key_pin_i : key_pin_i;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  // Synchroniser loads the released value (0 after normalisation) on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_norm;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Single-step / burst / free-run controller producing a one-cycle CPU
// clock enable from debounced board keys, plus a running step counter.
module step_clock_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_KEY        = 0,
  parameter int BURST_W         = 8,
  parameter int DIV_W           = 26,
  parameter int CNT_W           = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [1:0]          mode,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic [DIV_W-1:0]    burst_gap,
  input  logic [DIV_W-1:0]    run_div,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                step_en,
  output logic                busy,
  output logic [CNT_W-1:0]    step_count
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i    (CLOCK_50),
      .rst_i    (reset),
      .key_pin_i(KEY[g]),
      .level_o  (key_level[g]),
      .press_o  (key_press[g])
    );
  end

  state_e               state_q, state_d;
  logic [BURST_W-1:0]   rem_q, rem_d;
  logic [DIV_W-1:0]     gap_q, gap_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     lim_q, lim_d;
  logic                 step_q, step_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 sp;

  assign sp = key_press[STEP_KEY];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    div_d   = div_q;
    lim_d   = lim_q;
    step_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        case (mode)
          MODE_MANUAL: step_d = sp;
          MODE_BURST: begin
            if (sp) begin
              rem_d   = (burst_len == '0) ? BURST_W'(1) : burst_len;
              gap_d   = '0;
              state_d = ST_BURST;
            end
          end
          MODE_RUN: begin
            div_d   = '0;
            lim_d   = run_div;
            state_d = ST_RUN;
          end
          default: ;
        endcase
      end
      ST_BURST: begin
        // Only halt may cut a burst short; other mode changes wait for it.
        if (mode == MODE_HALT) begin
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          step_d = 1'b1;
          rem_d  = rem_q - BURST_W'(1);
          gap_d  = burst_gap;
          if (rem_q == BURST_W'(1)) state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - DIV_W'(1);
        end
      end
      ST_RUN: begin
        if (mode != MODE_RUN) begin
          state_d = ST_IDLE;
        end else if (div_q == lim_q) begin
          div_d  = '0;
          lim_d  = run_div;
          step_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    count_d = step_d ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      div_q   <= '0;
      lim_q   <= '0;
      step_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      div_q   <= div_d;
      lim_q   <= lim_d;
      step_q  <= step_d;
      count_q <= count_d;
    end
  end

  assign step_en    = step_q;
  assign busy       = (state_q != ST_IDLE);
  assign step_count = count_q;

endmodule
